fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, at least 2).
REQ-002 SHALL have parameter PC_INIT, default 32'h0, meaning the fetch PC after reset.
REQ-003 SHALL have port CLK  input  1  system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ihit  input  1  imemload is valid for imemaddr this cycle.
REQ-006 SHALL have port imemload  input  32  fetched instruction word.
REQ-007 SHALL have port imemREN  output  1  fetch request.
REQ-008 SHALL have port imemaddr  output  32  fetch address, equal to the PC register.
REQ-009 SHALL have port redirect  input  1  branch/jump resolved taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch target.
REQ-011 SHALL have port halt  input  1  level; suppresses new fetches.
REQ-012 SHALL have port deq  input  1  decode consumes the head entry.
REQ-013 SHALL have port valid_out  output  1  head entry present.
REQ-014 SHALL have port instr_out  output  32  head instruction, 0 when valid_out=0.
REQ-015 SHALL have port pcp4_out  output  32  head PC+4, 0 when valid_out=0.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-017 SHALL drive imemREN = !halt && !redirect && (count < DEPTH), evaluated on start-of-cycle count.
REQ-018 SHALL enqueue {imemload, pc+4} at tail and advance pc by 4 when imemREN && ihit.
REQ-019 SHALL pop the head when deq && valid_out; deq with valid_out=0 is ignored.
REQ-020 SHALL allow enqueue and pop in the same cycle; count unchanged; a full queue with deq does not accept a fetch that cycle (no pass-through when full).
REQ-021 SHALL wrap head/tail pointers modulo DEPTH; entries leave in fetch order.
REQ-022 SHALL on redirect clear count, head and tail to 0 and load pc with {redirect_pc[31:2],2'b00} at the next edge; redirect overrides ihit and deq in that cycle.
REQ-023 SHALL keep queue contents and pc while halt=1; deq still drains; redirect while halted still updates pc.
REQ-024 SHALL present the head combinationally from storage; minimum fetch-to-valid_out latency is 1 cycle.
REQ-025 SHALL never exceed count = DEPTH nor underflow 0.

Reset
REQ-026 SHALL on nRST=0, immediately and regardless of CLK: pc=PC_INIT, count=0, pointers=0, valid_out=0, instr_out=0, pcp4_out=0; storage contents need not be cleared.
REQ-027 SHALL discard any in-progress enqueue/pop when reset asserts mid-cycle.

Configuration
REQ-028 SHALL support macro FETCHQ_BYPASS_EN: when defined, if count=0 and imemREN && ihit, valid_out=1 and instr_out/pcp4_out come directly from imemload/pc+4 the same cycle; with deq the entry is consumed without being written, without deq it is enqueued normally.
REQ-029 SHALL, without FETCHQ_BYPASS_EN, assert valid_out only when count>0 (1-cycle minimum latency).

Structure
REQ-030 SHALL take word_t from cpu_types_pkg and add a packed struct fetchq_entry_t {word_t instr; word_t pcp4;} to that package.
REQ-031 SHALL place storage and pointers in one sub-module fetchq_buf (DEPTH parameter, write/pop/clear controls); PC and handshake logic stay in fetch_queue.

Verification
REQ-032 SHALL cover reset: PC_INIT=0, release nRST, ihit=1, deq=0 for 5 cycles -> imemaddr 0,4,8,12 then holds 16; count=4; imemREN=0.
REQ-033 SHALL cover order/wrap: DEPTH=4, fetch 6 words with deq every other cycle -> instr_out sequence matches fetch order across pointer wrap; pcp4_out = fetch address+4.
REQ-034 SHALL cover redirect with full queue plus ihit and deq: redirect_pc=32'h0000_0103 -> next cycle count=0, valid_out=0, imemaddr=32'h0000_0100.
REQ-035 SHALL cover halt: halt=1 with count=3, deq=1 for 4 cycles -> 3 pops, then valid_out=0, imemaddr unchanged, imemREN=0.
REQ-036 SHALL cover full plus deq: count=4, ihit=1, deq=1 -> count 3, no fetch accepted that cycle, accepted the next.
REQ-037 SHALL cover bypass: count=0, ihit=1, deq=1, imemload=32'h2002_0005 -> with FETCHQ_BYPASS_EN instr_out=32'h2002_0005 that cycle and count stays 0; without, valid_out=0 that cycle, then valid_out=1 the next.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types; the fetch queue entry pairs an instruction with its PC+4.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pcp4;
  } fetchq_entry_t;

endpackage

// File: rtl/fetchq_buf.sv
// Circular entry buffer for the fetch queue: storage, head/tail pointers and occupancy.
// Clear has priority over write and pop; entries are not reset, only the pointers.
module fetchq_buf
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         clear,
  input  logic                         write,
  input  fetchq_entry_t                wdata,
  input  logic                         pop,
  output fetchq_entry_t                head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetchq_entry_t   mem [DEPTH];
  logic [AW-1:0]   head_ptr;
  logic [AW-1:0]   tail_ptr;
  logic            do_write;
  logic            do_pop;

  assign do_write = write && !clear;
  assign do_pop   = pop && !clear;
  assign head     = mem[head_ptr];

  always_ff @(posedge CLK) begin
    if (do_write) mem[tail_ptr] <= wdata;
  end

  // power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_write) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)   head_ptr <= head_ptr + 1'b1;
      case ({do_write, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC register, fetch handshake and decode-side head presentation.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int    DEPTH   = 4,
  parameter word_t PC_INIT = 32'h0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         ihit,
  input  logic [31:0]                  imemload,
  output logic                         imemREN,
  output logic [31:0]                  imemaddr,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt,
  input  logic                         deq,
  output logic                         valid_out,
  output logic [31:0]                  instr_out,
  output logic [31:0]                  pcp4_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  word_t          pc;
  word_t          pcp4;
  logic           fetch;
  logic           has_entry;
  logic           byp;
  logic           write;
  logic           pop;
  fetchq_entry_t  head;
  fetchq_entry_t  wdata;
  fetchq_entry_t  head_sel;

  assign pcp4      = pc + 32'd4;
  assign imemaddr  = pc;
  assign imemREN   = !halt && !redirect && (count < FULL);
  assign fetch     = imemREN && ihit;
  assign has_entry = (count != '0);

`ifdef FETCHQ_BYPASS_EN
  assign byp = fetch && !has_entry;
`else
  assign byp = 1'b0;
`endif

  // a bypassed word consumed in the same cycle never touches storage
  assign write = fetch && !(byp && deq);
  assign pop   = deq && has_entry && !redirect;

  assign wdata.instr = imemload;
  assign wdata.pcp4  = pcp4;

  assign valid_out = has_entry || byp;
  assign head_sel  = has_entry ? head : wdata;
  assign instr_out = valid_out ? head_sel.instr : '0;
  assign pcp4_out  = valid_out ? head_sel.pcp4  : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= PC_INIT;
    end else if (redirect) begin
      pc <= redirect_pc & ~32'h3;
    end else if (fetch) begin
      pc <= pcp4;
    end
  end

  fetchq_buf #(.DEPTH(DEPTH)) u_buf (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (redirect),
    .write (write),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4, PC_INIT=0) with a scoreboard of fetched entries.
module tb_fetch_queue;

`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        deq = 1'b0;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pcp4_out;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [63:0] sb[$];

  always #5 CLK = ~CLK;

  fetch_queue #(.DEPTH(4), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .deq(deq), .valid_out(valid_out), .instr_out(instr_out), .pcp4_out(pcp4_out),
    .count(count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit m_ren();
    return !halt && !redirect && (sb.size() < 4);
  endfunction

  // drive one cycle's inputs mid-cycle; the memory model answers at the model PC
  task automatic drive(input bit ih, input bit dq, input bit rd, input logic [31:0] rpc, input bit hl);
    ihit = ih; deq = dq; redirect = rd; redirect_pc = rpc; halt = hl;
    imemload = mem_word(m_pc);
    #1;
  endtask

  // advance one clock and update the reference model from the inputs in effect
  task automatic tick();
    bit fetch, byp;
    fetch = m_ren() && ihit;
    byp = BYP && fetch && (sb.size() == 0);
    @(posedge CLK); #1;
    if (redirect) begin
      sb.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (deq && sb.size() > 0) void'(sb.pop_front());
      if (fetch && !(byp && deq)) sb.push_back({imemload, m_pc + 32'd4});
      if (fetch) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic reset_dut();
    nRST = 0; ihit = 0; deq = 0; redirect = 0; halt = 0;
    #2;
    nRST = 1;
    sb.delete();
    m_pc = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] addr_tab [5];
    addr_tab = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    n_checks++; if (instr_out !== 32'h0 || pcp4_out !== 32'h0) begin n_fail++; $display("FAIL reset_head got=%h/%h exp=0/0", instr_out, pcp4_out); end
    n_checks++; if (imemaddr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", imemaddr); end
    nRST = 1;
    m_pc = 32'h0; sb.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++; if (imemaddr !== addr_tab[i]) begin n_fail++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, imemaddr, addr_tab[i]); end
      tick();
    end
    drive(1, 0, 0, 0, 0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
    n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL fill_ren got=%b exp=0", imemREN); end
    n_checks++; if (imemaddr !== 32'd16) begin n_fail++; $display("FAIL fill_hold got=%h exp=10", imemaddr); end
    // asynchronous reset mid-cycle must clear immediately, discarding the pending fetch/pop
    deq = 1;
    nRST = 0; #1;
    n_checks++; if (count !== 3'd0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%0d/%b exp=0/0", count, valid_out); end
    n_checks++; if (imemaddr !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc got=%h exp=0", imemaddr); end
    reset_dut();
  endtask

  task automatic test_order_wrap();
    int fetched = 0;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      drive(fetched < 6, c % 2 == 1, 0, 0, 0);
      n_checks++; if (imemaddr !== m_pc) begin n_fail++; $display("FAIL order_addr c%0d got=%h exp=%h", c, imemaddr, m_pc); end
      if (deq && sb.size() > 0) begin
        n_checks++; if (instr_out !== sb[0][63:32]) begin n_fail++; $display("FAIL order_instr c%0d got=%h exp=%h", c, instr_out, sb[0][63:32]); end
        n_checks++; if (pcp4_out !== sb[0][31:0]) begin n_fail++; $display("FAIL order_pcp4 c%0d got=%h exp=%h", c, pcp4_out, sb[0][31:0]); end
      end
      if (m_ren() && ihit) fetched++;
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_checks++; if (count !== 3'd0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL order_drained got=%0d/%b exp=0/0", count, valid_out); end
    n_checks++; if (imemaddr !== 32'd24) begin n_fail++; $display("FAIL order_pc got=%h exp=18", imemaddr); end
  endtask

  task automatic test_full_deq();
    reset_dut();
    repeat (4) begin drive(1, 0, 0, 0, 0); tick(); end
    drive(1, 1, 0, 0, 0);
    n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL full_ren got=%b exp=0", imemREN); end
    n_checks++; if (instr_out !== sb[0][63:32]) begin n_fail++; $display("FAIL full_head got=%h exp=%h", instr_out, sb[0][63:32]); end
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_deq_count got=%0d exp=3", count); end
    drive(1, 0, 0, 0, 0);
    n_checks++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL refill_ren got=%b exp=1", imemREN); end
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL refill_count got=%0d exp=4", count); end
    n_checks++; if (imemaddr !== 32'd20) begin n_fail++; $display("FAIL refill_pc got=%h exp=14", imemaddr); end
  endtask

  task automatic test_redirect();
    drive(1, 1, 1, 32'h0000_0103, 0);
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count got=%0d exp=0", count); end
    n_checks++; if (valid_out !== 1'b0 || instr_out !== 32'h0) begin n_fail++; $display("FAIL redir_valid got=%b/%h exp=0/0", valid_out, instr_out); end
    n_checks++; if (imemaddr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_pc got=%h exp=00000100", imemaddr); end
  endtask

  task automatic test_halt();
    int pops = 0;
    repeat (3) begin drive(1, 0, 0, 0, 0); tick(); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 1);
      n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL halt_ren c%0d got=%b exp=0", i, imemREN); end
      if (sb.size() > 0) begin
        pops++;
        n_checks++; if (instr_out !== sb[0][63:32]) begin n_fail++; $display("FAIL halt_instr c%0d got=%h exp=%h", i, instr_out, sb[0][63:32]); end
      end
      tick();
    end
    drive(0, 0, 0, 0, 1);
    n_checks++; if (valid_out !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL halt_drained got=%b/%0d exp=0/0 pops=%0d", valid_out, count, pops); end
    n_checks++; if (imemaddr !== 32'h0000_010C) begin n_fail++; $display("FAIL halt_pc got=%h exp=0000010c", imemaddr); end
    drive(1, 0, 1, 32'h0000_0200, 1);
    tick();
    n_checks++; if (imemaddr !== 32'h0000_0200) begin n_fail++; $display("FAIL halt_redir_pc got=%h exp=00000200", imemaddr); end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_bypass();
    drive(1, 1, 0, 0, 0);
    imemload = 32'h2002_0005;
    #1;
    if (BYP) begin
      n_checks++; if (valid_out !== 1'b1 || instr_out !== 32'h2002_0005) begin n_fail++; $display("FAIL byp_same got=%b/%h exp=1/20020005", valid_out, instr_out); end
      n_checks++; if (pcp4_out !== 32'h0000_0204) begin n_fail++; $display("FAIL byp_pcp4 got=%h exp=00000204", pcp4_out); end
      tick();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count got=%0d exp=0", count); end
    end else begin
      n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL nobyp_same got=%b exp=0", valid_out); end
      tick();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (valid_out !== 1'b1 || instr_out !== 32'h2002_0005) begin n_fail++; $display("FAIL nobyp_next got=%b/%h exp=1/20020005", valid_out, instr_out); end
      n_checks++; if (count !== 3'd1 || sb.size() != 1) begin n_fail++; $display("FAIL nobyp_count got=%0d exp=1", count); end
    end
  endtask

  initial begin
    m_pc = 32'h0;
    #1;
    test_reset();
    test_order_wrap();
    test_full_deq();
    test_redirect();
    test_halt();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
